// File: rtl/boot_run_ctrl.sv
// Program loader and run controller: streams an image into imem/dmem, holds the core
// in reset while loading, then runs it until a halt fetch or the cycle budget expires.
// Optional BOOT_RUN_CTRL_HIST_EN adds last_insn / halt_cycle history outputs.
module boot_run_ctrl #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     IMEM_DEPTH = 64,
  parameter int unsigned     DMEM_DEPTH = 64,
  parameter int unsigned     AW         = 8,
  parameter int unsigned     MAX_CYCLES = 1024,
  parameter logic [XLEN-1:0] HALT_INSN  = XLEN'(32'h0000006f)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic            ld_sel,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_last,
  input  logic            restart,
  output logic            imem_we,
  output logic [AW-1:0]   imem_waddr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            dmem_we,
  output logic [AW-1:0]   dmem_waddr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            core_reset,
  input  logic [XLEN-1:0] core_insn,
  output logic            done,
  output logic            halted,
  output logic            timeout,
  output logic            addr_err,
`ifdef BOOT_RUN_CTRL_HIST_EN
  output logic [XLEN-1:0] last_insn,
  output logic [31:0]     halt_cycle,
`endif
  output logic [31:0]     cycle_count
);

  localparam int unsigned CW = 32;

  localparam logic [1:0] S_LOAD    = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]      state, state_d;
  logic            ld_ready_d, core_reset_d, done_d, halted_d, timeout_d, addr_err_d;
  logic            imem_we_d, dmem_we_d;
  logic [AW-1:0]   imem_waddr_d, dmem_waddr_d;
  logic [XLEN-1:0] imem_wdata_d, dmem_wdata_d;
  logic [CW-1:0]   cycle_count_d, count_inc;
  logic            xfer, imem_oor, dmem_oor;
`ifdef BOOT_RUN_CTRL_HIST_EN
  logic [XLEN-1:0] last_insn_d;
  logic [CW-1:0]   halt_cycle_d;
`endif

  assign xfer      = ld_valid && ld_ready;
  assign imem_oor  = CW'(ld_addr) >= CW'(IMEM_DEPTH);
  assign dmem_oor  = CW'(ld_addr) >= CW'(DMEM_DEPTH);
  // Saturating run counter: never wraps back to zero
  assign count_inc = (cycle_count == {CW{1'b1}}) ? cycle_count : cycle_count + CW'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    imem_we_d     = 1'b0;
    imem_waddr_d  = imem_waddr;
    imem_wdata_d  = imem_wdata;
    dmem_we_d     = 1'b0;
    dmem_waddr_d  = dmem_waddr;
    dmem_wdata_d  = dmem_wdata;
    halted_d      = halted;
    timeout_d     = timeout;
    addr_err_d    = addr_err;
    cycle_count_d = cycle_count;
`ifdef BOOT_RUN_CTRL_HIST_EN
    last_insn_d   = last_insn;
    halt_cycle_d  = halt_cycle;
`endif

    case (state)
      S_LOAD: begin
        if (xfer) begin
          if (!ld_sel) begin
            if (imem_oor) begin
              addr_err_d = 1'b1;
            end else begin
              imem_we_d    = 1'b1;
              imem_waddr_d = ld_addr;
              imem_wdata_d = ld_data;
            end
          end else begin
            if (dmem_oor) begin
              addr_err_d = 1'b1;
            end else begin
              dmem_we_d    = 1'b1;
              dmem_waddr_d = ld_addr;
              dmem_wdata_d = ld_data;
            end
          end
          if (ld_last) state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        cycle_count_d = count_inc;
`ifdef BOOT_RUN_CTRL_HIST_EN
        last_insn_d   = core_insn;
`endif
        // A halt fetched on the budget's final cycle still reports as halted
        if (core_insn == HALT_INSN) begin
          state_d  = S_DONE;
          halted_d = 1'b1;
`ifdef BOOT_RUN_CTRL_HIST_EN
          halt_cycle_d = count_inc;
`endif
        end else if (count_inc == CW'(MAX_CYCLES)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        if (restart) begin
          state_d       = S_LOAD;
          halted_d      = 1'b0;
          timeout_d     = 1'b0;
          addr_err_d    = 1'b0;
          cycle_count_d = '0;
`ifdef BOOT_RUN_CTRL_HIST_EN
          last_insn_d   = '0;
          halt_cycle_d  = '0;
`endif
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    ld_ready_d   = (state_d == S_LOAD);
    core_reset_d = (state_d != S_RUN);
    done_d       = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_LOAD;
      ld_ready    <= 1'b1;
      core_reset  <= 1'b1;
      imem_we     <= 1'b0;
      imem_waddr  <= '0;
      imem_wdata  <= '0;
      dmem_we     <= 1'b0;
      dmem_waddr  <= '0;
      dmem_wdata  <= '0;
      done        <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      addr_err    <= 1'b0;
      cycle_count <= '0;
`ifdef BOOT_RUN_CTRL_HIST_EN
      last_insn   <= '0;
      halt_cycle  <= '0;
`endif
    end else begin
      state       <= state_d;
      ld_ready    <= ld_ready_d;
      core_reset  <= core_reset_d;
      imem_we     <= imem_we_d;
      imem_waddr  <= imem_waddr_d;
      imem_wdata  <= imem_wdata_d;
      dmem_we     <= dmem_we_d;
      dmem_waddr  <= dmem_waddr_d;
      dmem_wdata  <= dmem_wdata_d;
      done        <= done_d;
      halted      <= halted_d;
      timeout     <= timeout_d;
      addr_err    <= addr_err_d;
      cycle_count <= cycle_count_d;
`ifdef BOOT_RUN_CTRL_HIST_EN
      last_insn   <= last_insn_d;
      halt_cycle  <= halt_cycle_d;
`endif
    end
  end

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Self-checking bench for boot_run_ctrl: a memory + sequential-fetch core model and an
// image-level run predictor (first halt within the budget, else timeout).
module tb_boot_run_ctrl;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned DMEM_DEPTH = 64;
  localparam int unsigned AW         = 8;
  localparam int unsigned MAX_CYCLES = 8;
  localparam logic [31:0] HALT       = 32'h0000006f;

  logic            clock = 1'b0;
  logic            reset;
  logic            ld_valid, ld_sel, ld_last, restart;
  logic [AW-1:0]   ld_addr;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready, imem_we, dmem_we, core_reset, done, halted, timeout, addr_err;
  logic [AW-1:0]   imem_waddr, dmem_waddr;
  logic [XLEN-1:0] imem_wdata, dmem_wdata, core_insn;
  logic [31:0]     cycle_count;

  int vectors = 0;
  int errors  = 0;

  boot_run_ctrl #(
    .XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .AW(AW),
    .MAX_CYCLES(MAX_CYCLES), .HALT_INSN(HALT)
  ) dut (
    .clock(clock), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .restart(restart),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .core_reset(core_reset), .core_insn(core_insn),
    .done(done), .halted(halted), .timeout(timeout), .addr_err(addr_err),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  // Environment: memories written through the write ports and a straight-line fetch core
  logic [31:0] imem_m [0:255];
  logic [31:0] dmem_m [0:255];
  logic [7:0]  pc = 8'd0;
  int imem_pulses = 0;
  int dmem_pulses = 0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem_m[i] = 32'd0;
      dmem_m[i] = 32'd0;
    end
  end

  always @(posedge clock) begin
    if (imem_we) imem_m[imem_waddr] <= imem_wdata;
    if (dmem_we) dmem_m[dmem_waddr] <= dmem_wdata;
    pc <= core_reset ? 8'd0 : pc + 8'd1;
  end
  assign core_insn = imem_m[pc];

  always @(negedge clock) begin
    if (imem_we) imem_pulses <= imem_pulses + 1;
    if (dmem_we) dmem_pulses <= dmem_pulses + 1;
  end

  // Reference image: what the loader was asked to place in instruction memory
  logic [31:0] img [0:255];
  initial for (int i = 0; i < 256; i++) img[i] = 32'd0;

  logic        obs_iwe, obs_dwe;
  logic [7:0]  obs_addr;
  logic [31:0] obs_data;

  function automatic logic [31:0] rand_insn();
    logic [31:0] x;
    do x = $urandom; while (x == HALT);
    return x;
  endfunction

  function automatic void predict(output logic [31:0] cnt, output logic h);
    cnt = MAX_CYCLES;
    h   = 1'b0;
    for (int k = 0; k < int'(MAX_CYCLES); k++) begin
      if (img[k] == HALT) begin
        cnt = 32'(k + 1);
        h   = 1'b1;
        break;
      end
    end
  endfunction

  // Drive one word starting at a negedge; returns at the following negedge
  task automatic send_word(input logic sel, input logic [7:0] addr, input logic [31:0] data,
                           input logic last);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data; ld_last = last;
    if (!sel && addr < IMEM_DEPTH) img[addr] = data;
    @(posedge clock); #1;
    obs_iwe  = imem_we;
    obs_dwe  = dmem_we;
    obs_addr = sel ? dmem_waddr : imem_waddr;
    obs_data = sel ? dmem_wdata : imem_wdata;
    @(negedge clock);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    repeat (200) begin
      @(negedge clock);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_image(input int n, input int hp);
    for (int k = 0; k < n; k++)
      send_word(1'b0, 8'(k), (k == hp) ? HALT : rand_insn(), k == n - 1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({ld_ready, core_reset, done, halted, timeout, addr_err, imem_we, dmem_we} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 11000000",
               {ld_ready, core_reset, done, halted, timeout, addr_err, imem_we, dmem_we});
    end
    vectors++;
    if ({cycle_count, imem_waddr, imem_wdata, dmem_waddr, dmem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: count=%0d iaddr=%0d idata=%h daddr=%0d ddata=%h want all 0",
               cycle_count, imem_waddr, imem_wdata, dmem_waddr, dmem_wdata);
    end
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({ld_ready, core_reset, done, cycle_count} !== {3'b110, 32'd0}) begin
      errors++;
      $display("FAIL reset_release: ready=%b core_reset=%b done=%b count=%0d want 1 1 0 0",
               ld_ready, core_reset, done, cycle_count);
    end
  endtask

  task automatic check_run(input string name);
    bit ok;
    logic [31:0] ecnt;
    logic eh;
    wait_done(ok);
    predict(ecnt, eh);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_done: done never rose within 200 cycles", name);
    end
    vectors++;
    if ({cycle_count, halted, timeout, core_reset} !== {ecnt, eh, !eh, 1'b1}) begin
      errors++;
      $display("FAIL %s_result: count=%0d halted=%b timeout=%b core_reset=%b want %0d %b %b 1",
               name, cycle_count, halted, timeout, core_reset, ecnt, eh, !eh);
    end
  endtask

  task automatic test_restart_clears();
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    vectors++;
    if ({done, halted, timeout, addr_err, ld_ready, core_reset, cycle_count} !== {6'b000011, 32'd0}) begin
      errors++;
      $display("FAIL restart_clear: done=%b halted=%b timeout=%b addr_err=%b ready=%b count=%0d want 0 0 0 0 1 0",
               done, halted, timeout, addr_err, ld_ready, cycle_count);
    end
  endtask

  task automatic test_load_run();
    logic [31:0] dv [5] = '{32'd5, 32'd10, 32'd20, 32'd30, 32'd40};
    logic [31:0] d;
    imem_pulses = 0;
    dmem_pulses = 0;
    for (int i = 0; i <= 40; i++) begin
      d = (i == 40) ? HALT : rand_insn();
      send_word(1'b0, 8'(i), d, 1'b0);
      vectors++;
      if ({obs_iwe, obs_dwe, obs_addr, obs_data} !== {2'b10, 8'(i), d}) begin
        errors++;
        $display("FAIL imem_write[%0d]: we=%b dwe=%b addr=%0d data=%h want 1 0 %0d %h",
                 i, obs_iwe, obs_dwe, obs_addr, obs_data, i, d);
      end
    end
    for (int i = 0; i < 5; i++) begin
      send_word(1'b1, 8'(i), dv[i], i == 4);
      vectors++;
      if ({obs_iwe, obs_dwe, obs_addr, obs_data} !== {2'b01, 8'(i), dv[i]}) begin
        errors++;
        $display("FAIL dmem_write[%0d]: iwe=%b we=%b addr=%0d data=%h want 0 1 %0d %h",
                 i, obs_iwe, obs_dwe, obs_addr, obs_data, i, dv[i]);
      end
    end
    vectors++;
    if ({core_reset, ld_ready} !== 2'b10) begin
      errors++;
      $display("FAIL release_cycle: core_reset=%b ready=%b want 1 0", core_reset, ld_ready);
    end
    @(negedge clock);
    vectors++;
    if (core_reset !== 1'b0) begin
      errors++;
      $display("FAIL core_reset_fall: core_reset=%b want 0 two cycles after last transfer", core_reset);
    end
    check_run("load41");
    vectors++;
    if (imem_pulses != 41 || dmem_pulses != 5) begin
      errors++;
      $display("FAIL pulse_count: imem=%0d dmem=%0d want 41 5", imem_pulses, dmem_pulses);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (dmem_m[i] !== dv[i]) begin
        errors++;
        $display("FAIL dmem_content[%0d]: got %0d want %0d", i, dmem_m[i], dv[i]);
      end
    end
  endtask

  task automatic test_done_ignores_load();
    logic [31:0] c;
    c = cycle_count;
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 8'd3; ld_data = rand_insn(); ld_last = 1'b1;
    repeat (3) begin
      @(negedge clock);
      vectors++;
      if ({imem_we, dmem_we, ld_ready, done, cycle_count} !== {4'b0001, c}) begin
        errors++;
        $display("FAIL done_hold: iwe=%b dwe=%b ready=%b done=%b count=%0d want 0 0 0 1 %0d",
                 imem_we, dmem_we, ld_ready, done, cycle_count, c);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic test_halt_first();
    test_restart_clears();
    send_word(1'b0, 8'd0, HALT, 1'b1);
    check_run("halt_first");
  endtask

  task automatic test_timeout();
    test_restart_clears();
    load_image(10, -1);
    check_run("timeout");
  endtask

  task automatic test_halt_at_max();
    test_restart_clears();
    load_image(8, 7);
    check_run("halt_at_max");
  endtask

  task automatic test_addr_err();
    test_restart_clears();
    send_word(1'b0, 8'(IMEM_DEPTH), rand_insn(), 1'b0);
    vectors++;
    if ({obs_iwe, obs_dwe, addr_err} !== 3'b001) begin
      errors++;
      $display("FAIL imem_oor: iwe=%b dwe=%b addr_err=%b want 0 0 1", obs_iwe, obs_dwe, addr_err);
    end
    send_word(1'b1, 8'(DMEM_DEPTH), 32'hdead_beef, 1'b0);
    vectors++;
    if ({obs_iwe, obs_dwe, addr_err} !== 3'b001) begin
      errors++;
      $display("FAIL dmem_oor: iwe=%b dwe=%b addr_err=%b want 0 0 1", obs_iwe, obs_dwe, addr_err);
    end
    send_word(1'b0, 8'd0, rand_insn(), 1'b0);
    vectors++;
    if ({obs_iwe, obs_addr, addr_err} !== {1'b1, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL after_oor: iwe=%b addr=%0d addr_err=%b want 1 0 1", obs_iwe, obs_addr, addr_err);
    end
    send_word(1'b0, 8'd1, HALT, 1'b1);
    check_run("addr_err_run");
    vectors++;
    if (addr_err !== 1'b1) begin
      errors++;
      $display("FAIL addr_err_sticky: addr_err=%b want 1 in DONE", addr_err);
    end
    test_restart_clears();
  endtask

  task automatic test_reset_mid_run();
    load_image(10, -1);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({core_reset, ld_ready, done, cycle_count} !== {3'b110, 32'd0}) begin
      errors++;
      $display("FAIL async_reset: core_reset=%b ready=%b done=%b count=%0d want 1 1 0 0",
               core_reset, ld_ready, done, cycle_count);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({core_reset, ld_ready, cycle_count} !== {2'b11, 32'd0}) begin
      errors++;
      $display("FAIL reset_relaunch: core_reset=%b ready=%b count=%0d want 1 1 0",
               core_reset, ld_ready, cycle_count);
    end
  endtask

  task automatic test_restart_ignored();
    load_image(10, -1);
    @(negedge clock);
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    check_run("restart_in_run");
    test_restart_clears();
  endtask

  task automatic test_back_to_back();
    logic [31:0] first;
    logic [31:0] words [12];
    int n, hp;
    for (int it = 0; it < 4; it++) begin
      n  = $urandom_range(1, 12);
      hp = $urandom_range(0, 13);
      for (int k = 0; k < n; k++) words[k] = (k == hp) ? HALT : rand_insn();
      for (int k = 0; k < n; k++) send_word(1'b0, 8'(k), words[k], k == n - 1);
      check_run("rand_run");
      first = cycle_count;
      test_restart_clears();
      for (int k = 0; k < n; k++) send_word(1'b0, 8'(k), words[k], k == n - 1);
      check_run("rand_rerun");
      vectors++;
      if (cycle_count !== first) begin
        errors++;
        $display("FAIL rerun_repeat: count=%0d want %0d", cycle_count, first);
      end
      test_restart_clears();
    end
  endtask

  initial begin
    reset = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    ld_last = 1'b0; restart = 1'b0;
    test_reset();
    test_load_run();
    test_done_ignores_load();
    test_halt_first();
    test_timeout();
    test_halt_at_max();
    test_addr_err();
    test_reset_mid_run();
    test_restart_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
